// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
// Stall and flush bit positions are named so the pattern constants read as stage lists.
package pipe_stall_ctrl_pkg;

  localparam int unsigned STALL_W     = 5;
  localparam int unsigned STALL_PC    = 0;
  localparam int unsigned STALL_IFID  = 1;
  localparam int unsigned STALL_IDEX  = 2;
  localparam int unsigned STALL_EXMEM = 3;
  localparam int unsigned STALL_MEMWB = 4;

  localparam int unsigned FLUSH_W    = 2;
  localparam int unsigned FLUSH_IFID = 0;
  localparam int unsigned FLUSH_IDEX = 1;

  // Wide enough for the largest legal MEM_TIMEOUT (65535).
  localparam int unsigned WAIT_W = 16;

  typedef logic [4:0]         reg_addr_t;
  typedef logic [STALL_W-1:0] stall_t;
  typedef logic [FLUSH_W-1:0] flush_t;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  localparam stall_t STALL_NONE     = '0;
  localparam stall_t STALL_LOAD_USE = stall_t'((1 << STALL_PC) | (1 << STALL_IFID) | (1 << STALL_IDEX));
  localparam stall_t STALL_MEM      = STALL_LOAD_USE | stall_t'(1 << STALL_EXMEM);
  localparam stall_t STALL_ALL      = STALL_MEM | stall_t'(1 << STALL_MEMWB);

  localparam flush_t FLUSH_NONE   = '0;
  localparam flush_t FLUSH_ALL    = flush_t'((1 << FLUSH_IFID) | (1 << FLUSH_IDEX));
  localparam flush_t FLUSH_BUBBLE = flush_t'(1 << FLUSH_IDEX);

  function automatic logic reads_reg(logic en, reg_addr_t rs, reg_addr_t rd);
    return en && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard inputs from ID/EX/MEM and stall/flush controls back to the pipeline.
// The pipeline side is the master; the stall sequencer is the slave.
interface pipe_stall_ctrl_if;
  import pipe_stall_ctrl_pkg::*;

  reg_addr_t id_rs1_i;
  reg_addr_t id_rs2_i;
  logic      id_read1_e_i;
  logic      id_read2_e_i;
  logic      ex_memread_i;
  reg_addr_t ex_rd_i;
  logic      ex_branch_taken_i;
  logic      mem_req_i;
  logic      mem_ready_i;
  stall_t    stall_o;
  flush_t    flush_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_read1_e_i, id_read2_e_i,
    output ex_memread_i, ex_rd_i, ex_branch_taken_i,
    output mem_req_i, mem_ready_i,
    input  stall_o, flush_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_read1_e_i, id_read2_e_i,
    input  ex_memread_i, ex_rd_i, ex_branch_taken_i,
    input  mem_req_i, mem_ready_i,
    output stall_o, flush_o
  );
endinterface

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset; holds at all-ones instead of wrapping.
module pipe_stall_ctrl_sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Hazard and stall sequencer for a 5-stage RV32I pipeline.
// state       | meaning
// ST_RUN      | normal issue; branch flush and load-use bubble resolved here
// ST_MEM_WAIT | data memory busy; IF..EX held, bubbles drain into WB
// ST_ERR      | memory timeout; whole pipe frozen until reset
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  pipe_stall_ctrl_if.slave    hz,
  output logic                mem_err_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_wait, load_use;
  stall_t            run_stall, stall_d;
  flush_t            run_flush, flush_d;
  logic              run_flush_evt, flush_evt;
  logic              mem_err_d;

  assign mem_wait = hz.mem_req_i && !hz.mem_ready_i;
  assign load_use = hz.ex_memread_i && (hz.ex_rd_i != '0) &&
                    (reads_reg(hz.id_read1_e_i, hz.id_rs1_i, hz.ex_rd_i) ||
                     reads_reg(hz.id_read2_e_i, hz.id_rs2_i, hz.ex_rd_i));

  // Controls when memory is not blocking: a taken branch squashes ID, so it beats load-use.
  always_comb begin
    run_stall     = STALL_NONE;
    run_flush     = FLUSH_NONE;
    run_flush_evt = 1'b0;
    if (hz.ex_branch_taken_i) begin
      run_flush     = FLUSH_ALL;
      run_flush_evt = 1'b1;
    end else if (load_use) begin
      run_stall = STALL_LOAD_USE;
      run_flush = FLUSH_BUBBLE;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    stall_d   = STALL_NONE;
    flush_d   = FLUSH_NONE;
    flush_evt = 1'b0;
    mem_err_d = 1'b0;
    if (rst_i) begin
      flush_d = FLUSH_ALL;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (mem_wait) begin
            stall_d = STALL_MEM;
            state_d = ST_MEM_WAIT;
            wait_d  = WAIT_W'(1);
          end else begin
            stall_d   = run_stall;
            flush_d   = run_flush;
            flush_evt = run_flush_evt;
          end
        end
        ST_MEM_WAIT: begin
          if (hz.mem_ready_i) begin
            stall_d   = run_stall;
            flush_d   = run_flush;
            flush_evt = run_flush_evt;
            state_d   = ST_RUN;
          end else begin
            stall_d = STALL_MEM;
            if (wait_q == WAIT_LAST) begin
              state_d = ST_ERR;
            end else begin
              wait_d = wait_q + WAIT_W'(1);
            end
          end
        end
        ST_ERR: begin
          stall_d   = STALL_ALL;
          mem_err_d = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign hz.stall_o = stall_d;
  assign hz.flush_o = flush_d;
  assign mem_err_o  = mem_err_d;

  pipe_stall_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_d[STALL_PC]),
    .cnt_o (stall_cnt_o)
  );

  pipe_stall_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_evt),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed hazard scenarios followed by random traffic,
// with expectations from a cycle-level behavioural model of the hazard rules.
module tb_pipe_stall_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  typedef struct {
    int stall;
    int flush;
    int err;
    int scnt;
    int fcnt;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic       mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .hz          (bus),
    .mem_err_o   (mem_err_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   drive_done = 1'b0;

  // Model state: consecutive blocked memory cycles, error flag, counters.
  int m_blocked = 0;
  bit m_err     = 1'b0;
  int m_scnt    = 0;
  int m_fcnt    = 0;

  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // One clock of stimulus; the expected response for this cycle is queued for the monitor.
  task automatic cycle(input bit rst, input int rs1, input int rs2, input bit r1e, input bit r2e,
                       input bit ld, input int rd, input bit br, input bit req, input bit rdy);
    exp_t e;
    bit   lu;
    @(posedge clk_i);
    #1;
    rst_i                 = rst;
    bus.id_rs1_i          = 5'(rs1);
    bus.id_rs2_i          = 5'(rs2);
    bus.id_read1_e_i      = r1e;
    bus.id_read2_e_i      = r2e;
    bus.ex_memread_i      = ld;
    bus.ex_rd_i           = 5'(rd);
    bus.ex_branch_taken_i = br;
    bus.mem_req_i         = req;
    bus.mem_ready_i       = rdy;

    e.scnt = m_scnt;
    e.fcnt = m_fcnt;
    e.stall = 0; e.flush = 0; e.err = 0;
    lu = ld && (rd != 0) && ((r1e && rs1 == rd) || (r2e && rs2 == rd));
    if (rst) begin
      e.flush = 3;
      m_blocked = 0; m_err = 0; m_scnt = 0; m_fcnt = 0;
    end else if (m_err) begin
      e.stall = 5'h1F;
      e.err   = 1;
    end else if ((m_blocked > 0) ? !rdy : (req && !rdy)) begin
      e.stall = 5'h0F;
      m_blocked++;
      if (m_blocked == MEM_TIMEOUT) begin
        m_err = 1;
        m_blocked = 0;
      end
    end else begin
      m_blocked = 0;
      if (br) begin
        e.flush = 3;
        if (m_fcnt < CNT_MAX) m_fcnt++;
      end else if (lu) begin
        e.stall = 5'h07;
        e.flush = 2;
      end
    end
    if (!rst && (e.stall & 1) && m_scnt < CNT_MAX) m_scnt++;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every cycle the DUT presents a full control word; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall_o",     int'(bus.stall_o),   e.stall);
        chk("flush_o",     int'(bus.flush_o),   e.flush);
        chk("mem_err_o",   int'(mem_err_o),     e.err);
        chk("stall_cnt_o", int'(stall_cnt_o),   e.scnt);
        chk("flush_cnt_o", int'(flush_cnt_o),   e.fcnt);
      end
    end
  end

  initial begin
    bus.id_rs1_i = '0; bus.id_rs2_i = '0; bus.id_read1_e_i = 0; bus.id_read2_e_i = 0;
    bus.ex_memread_i = 0; bus.ex_rd_i = '0; bus.ex_branch_taken_i = 0;
    bus.mem_req_i = 0; bus.mem_ready_i = 0;
    @(posedge clk_i);

    do_reset(); do_reset();
    // Load-use on rs1, then quiet cycles showing the single bubble and stall count.
    cycle(0, 5, 0, 1, 0, 1, 5, 0, 0, 0);
    idle(2);
    // x0 destination and disabled rs2 read must not stall.
    cycle(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    cycle(0, 1, 7, 1, 0, 1, 7, 0, 0, 0);
    // Load-use via rs2.
    cycle(0, 1, 9, 0, 1, 1, 9, 0, 0, 0);
    // Taken branch, and branch together with load-use.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(0, 3, 0, 1, 0, 1, 3, 1, 0, 0);
    idle(1);

    // Memory wait of three cycles, then release.
    do_reset();
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    // Ready on the first request cycle: no stall.
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);

    // Timeout into ERR, held while inputs toggle, then reset clears it.
    do_reset();
    repeat (6) cycle(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 2, 0, 1, 0, 1, 2, 1, 1, 1);
    do_reset();
    idle(2);

    // Branch held across a 2-cycle wait flushes once on release; load-use deferred likewise.
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(1);
    repeat (2) cycle(0, 4, 0, 1, 0, 1, 4, 0, 1, 0);
    cycle(0, 4, 0, 1, 0, 1, 4, 0, 1, 1);
    idle(1);
    // Reset mid-wait forgets everything.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    do_reset();
    idle(1);

    // Random traffic with small register indices so hazards are frequent; counters saturate.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 2) == 0), $urandom_range(0, 3),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
    end

    drive_done = 1'b1;
    repeat (3) @(posedge clk_i);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
